// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding and frame-format defaults
// common to uart_rx and the future uart_tx.
package uart_pkg;

    localparam int UART_NB_DATA    = 8;
    localparam int UART_SB_TICKS   = 16;
    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_DATA  = 2'b10,
        ST_STOP  = 2'b11
    } uart_rx_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous single-bit inputs (serial lines,
// buttons, switches). The reset value is chosen to match the input's idle level.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Metastability stage followed by the stable output stage
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1-style UART receiver driven by a 16x oversampling tick stream; emits each
// byte with a one-clock done pulse and flags frames whose stop bit is low.
module uart_rx
    import uart_pkg::*;
#(
    parameter int NB_DATA    = UART_NB_DATA,
    parameter int SB_TICKS   = UART_SB_TICKS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_ticks,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rx_done,
    output logic               o_frame_error
);

    localparam int TICK_W = $clog2(max_int(OVERSAMPLE, SB_TICKS));
    localparam int BIT_W  = $clog2(NB_DATA);

    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_BIT  = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] TICK_STOP = TICK_W'(SB_TICKS - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(NB_DATA - 1);

    logic                 rx_s;
    uart_rx_state_e       state_q;
    logic [TICK_W-1:0]    tick_q;
    logic [BIT_W-1:0]     bit_q;
    logic [NB_DATA-1:0]   shreg_q;
    logic [NB_DATA-1:0]   data_q;
    logic                 rx_done_q;
    logic                 frame_error_q;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync_rx (
        .clk_i (i_clock),
        .rst_i (i_reset),
        .d_i   (i_rx),
        .q_o   (rx_s)
    );

    // Frame FSM: start detection, mid-bit sampling and registered result pulses
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q       <= ST_IDLE;
            tick_q        <= '0;
            bit_q         <= '0;
            shreg_q       <= '0;
            data_q        <= '0;
            rx_done_q     <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            rx_done_q     <= 1'b0;
            frame_error_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // Start detection does not wait for a tick
                    if (!rx_s) begin
                        state_q <= ST_START;
                        tick_q  <= '0;
                    end
                end
                ST_START: begin
                    if (i_ticks) begin
                        if (tick_q == TICK_MID) begin
                            tick_q <= '0;
                            bit_q  <= '0;
                            state_q <= rx_s ? ST_IDLE : ST_DATA;
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (i_ticks) begin
                        if (tick_q == TICK_BIT) begin
                            shreg_q <= {rx_s, shreg_q[NB_DATA-1:1]};
                            tick_q  <= '0;
                            if (bit_q == BIT_LAST) begin
                                state_q <= ST_STOP;
                            end else begin
                                bit_q <= bit_q + 1'b1;
                            end
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (i_ticks) begin
                        if (tick_q == TICK_STOP) begin
                            if (rx_s) begin
                                data_q    <= shreg_q;
                                rx_done_q <= 1'b1;
                            end else begin
                                frame_error_q <= 1'b1;
                            end
                            tick_q  <= '0;
                            state_q <= ST_IDLE;
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tick_q  <= '0;
                end
            endcase
        end
    end

    assign o_data        = data_q;
    assign o_rx_done     = rx_done_q;
    assign o_frame_error = frame_error_q;

endmodule
